// File: rtl/fir_core_arbiter.sv
// fir_core_arbiter: round-robin scheduler sharing one ap_ctrl_hs FIR kernel among NUM_REQ requesters,
// with per-requester done/drop pulses, run latency capture and a sticky watchdog flag.
module fir_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LAT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_start,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic [NUM_REQ-1:0]         req_done,
    output logic [NUM_REQ-1:0]         req_drop,
    output logic                       core_ap_start,
    input  logic                       core_ap_ready,
    input  logic                       core_ap_done,
    input  logic                       core_ap_idle,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [LAT_W-1:0]           last_latency,
    output logic                       err_timeout
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [LAT_W-1:0] LAT_TO = LAT_W'(TIMEOUT);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
    state_t state, state_n;
    logic [NUM_REQ-1:0] pending, take;
    logic [ID_W-1:0] rr_ptr, sel, cand;
    logic found, grab, active, finish;
    logic [LAT_W-1:0] lat_cnt, lat_inc;
    int idx;

    // Descending scan so the candidate closest to rr_ptr is written last and wins.
    always_comb begin
        sel = '0;
        found = 1'b0;
        idx = 0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            cand = ID_W'(idx >= NUM_REQ ? idx - NUM_REQ : idx);
            if (pending[cand]) begin
                sel = cand;
                found = 1'b1;
            end
        end
    end

    assign grab = state == IDLE && found && core_ap_idle;
    assign take = grab ? NUM_REQ'(1) << sel : '0;
    assign active = state == START || state == RUN;
    assign finish = active && state_n == DONE;
    assign lat_inc = &lat_cnt ? lat_cnt : lat_cnt + LAT_W'(1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grab ? START : IDLE;
            START:   state_n = core_ap_ready ? (core_ap_done ? DONE : RUN) : START;
            RUN:     state_n = core_ap_done ? DONE : RUN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pending <= '0;
            rr_ptr <= '0;
            req_grant <= '0;
            req_done <= '0;
            req_drop <= '0;
            core_ap_start <= 1'b0;
            busy <= 1'b0;
            grant_id <= '0;
            last_latency <= '0;
            err_timeout <= 1'b0;
            lat_cnt <= '0;
        end else begin
            state <= state_n;
            pending <= (pending & ~take) | req_start;
            req_drop <= req_start & pending & ~take;
            req_done <= finish ? req_grant : '0;
            core_ap_start <= state_n == START;
            busy <= state_n != IDLE;
            req_grant <= grab ? take : (state_n == IDLE ? '0 : req_grant);
            lat_cnt <= grab ? '0 : (active ? lat_inc : lat_cnt);
            if (grab)
                grant_id <= sel;
            // Latency includes the ap_done cycle, so capture the incremented value.
            if (finish) begin
                last_latency <= lat_inc;
                rr_ptr <= grant_id == LAST_ID ? '0 : grant_id + ID_W'(1);
            end
            if (active && lat_cnt == LAT_TO)
                err_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_core_arbiter.sv
// tb_fir_core_arbiter: directed and randomized runs against a transaction-level model
// of pending requests, round-robin choice, latency and watchdog.
module tb_fir_core_arbiter;
    localparam int N = 4;
    localparam int LW = 6;
    localparam int TO = 16;
    localparam int LMAX = (1 << LW) - 1;

    logic clock = 1'b0;
    logic reset;
    logic [N-1:0] req_start, req_grant, req_done, req_drop;
    logic core_ap_start, core_ap_ready, core_ap_done, core_ap_idle, busy, err_timeout;
    logic [1:0] grant_id;
    logic [LW-1:0] last_latency;
    int checks = 0;
    int errors = 0;
    logic [N-1:0] pend_m;
    int ptr_m;
    int waited;
    int guard;

    fir_core_arbiter #(.NUM_REQ(N), .LAT_W(LW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .req_start(req_start), .req_grant(req_grant),
        .req_done(req_done), .req_drop(req_drop), .core_ap_start(core_ap_start),
        .core_ap_ready(core_ap_ready), .core_ap_done(core_ap_done), .core_ap_idle(core_ap_idle),
        .busy(busy), .grant_id(grant_id), .last_latency(last_latency), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (pend_m[(ptr_m + k) % N]) return (ptr_m + k) % N;
        return -1;
    endfunction

    task automatic request(input logic [N-1:0] m);
        req_start = m;
        tick;
        req_start = '0;
        chk("drop_on_request", req_drop, m & pend_m);
        pend_m = pend_m | m;
    endtask

    // One kernel run: ready r cycles and done d cycles after the first START cycle.
    task automatic serve(input int r, input int d, input bit noise, input logic [N-1:0] inj, output int w);
        int id;
        logic [N-1:0] p, exp_drop;
        id = pick();
        chk("model_has_pending", id >= 0, 1);
        w = 0;
        while (!core_ap_start && w < 8) begin
            tick;
            w++;
        end
        chk("start_seen", core_ap_start, 1);
        if (id >= 0) pend_m[id] = 1'b0;
        chk("grant_onehot", req_grant, 1 << id);
        chk("grant_id", grant_id, id);
        chk("busy_run", busy, 1);
        exp_drop = '0;
        for (int c = 0; c <= d; c++) begin
            chk("ap_start_level", core_ap_start, c <= r);
            chk("drop_during_run", req_drop, exp_drop);
            chk("no_early_done", req_done, 0);
            core_ap_ready = c == r;
            core_ap_done = c == d;
            core_ap_idle = 1'b0;
            p = noise ? (($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0)
                      : ((c == 0 || c == 2) ? inj : '0);
            req_start = p;
            exp_drop = p & pend_m;
            pend_m = pend_m | p;
            tick;
        end
        core_ap_ready = 1'b0;
        core_ap_done = 1'b0;
        core_ap_idle = 1'b1;
        req_start = '0;
        chk("req_done_pulse", req_done, 1 << id);
        chk("drop_after_run", req_drop, exp_drop);
        chk("last_latency", last_latency, (d + 1 > LMAX) ? LMAX : d + 1);
        chk("ap_start_low_done", core_ap_start, 0);
        tick;
        chk("req_done_single", req_done, 0);
        chk("grant_released", req_grant, 0);
        chk("busy_idle", busy, 0);
        chk("grant_id_held", grant_id, id);
        ptr_m = (id + 1) % N;
        if (pend_m != 0) begin
            tick;
            chk("next_start_d3", core_ap_start, 1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_start = '0;
        core_ap_ready = 1'b0;
        core_ap_done = 1'b0;
        core_ap_idle = 1'b1;
        pend_m = '0;
        ptr_m = 0;
        repeat (3) tick;
        chk("rst_grant", req_grant, 0);
        chk("rst_done", req_done, 0);
        chk("rst_drop", req_drop, 0);
        chk("rst_ap_start", core_ap_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_latency", last_latency, 0);
        chk("rst_err", err_timeout, 0);
        reset = 1'b0;
        tick;
        chk("idle_busy", busy, 0);

        // Round-robin: all four at once, 5-cycle runs.
        request(4'hF);
        for (int k = 0; k < N; k++) begin
            chk("rr_order", pick(), k);
            serve($urandom_range(0, 4), 4, 1'b0, '0, waited);
        end

        // Single request to requester 2: ready one cycle in, done after 9 cycles.
        request(4'b0100);
        serve(1, 8, 1'b0, '0, waited);
        chk("start_two_after_pulse", waited, 1);

        // Ready and done together in the first START cycle.
        request(4'b1000);
        serve(0, 0, 1'b0, '0, waited);

        // Duplicate request from requester 1 during requester 0's run.
        request(4'b0001);
        serve(1, 5, 1'b0, 4'b0010, waited);
        serve(2, 3, 1'b0, '0, waited);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("no_extra_run", core_ap_start, 0);
        end

        // Pulse on the grant cycle becomes a new request and is not dropped.
        req_start = 4'b0010;
        tick;
        pend_m = 4'b0010;
        req_start = 4'b0010;
        tick;
        req_start = '0;
        chk("grant_cycle_no_drop", req_drop, 0);
        serve(1, 2, 1'b0, '0, waited);
        pend_m = pend_m | 4'b0010;
        serve(0, 1, 1'b0, '0, waited);

        // Kernel not idle holds off the grant.
        core_ap_idle = 1'b0;
        request(4'b0001);
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("hold_while_busy_kernel", core_ap_start, 0);
        end
        core_ap_idle = 1'b1;
        tick;
        chk("start_after_idle", core_ap_start, 1);
        serve(0, 2, 1'b0, '0, waited);

        // Randomized rounds with stray request pulses during runs.
        for (int rnd = 0; rnd < 6; rnd++) begin
            request(N'($urandom_range(1, (1 << N) - 1)));
            guard = 0;
            while (pend_m != 0 && guard < 40) begin
                int r;
                r = $urandom_range(0, 3);
                serve(r, r + $urandom_range(0, 6), 1'b1, '0, waited);
                guard++;
            end
        end
        chk("no_err_short_runs", err_timeout, 0);

        // Latency saturation.
        request(4'b0001);
        serve(1, 69, 1'b0, '0, waited);

        // Watchdog: 40-cycle run to requester 2, flag sticky afterwards.
        request(4'b0100);
        serve(2, 39, 1'b0, '0, waited);
        chk("err_set", err_timeout, 1);
        repeat (3) tick;
        chk("err_sticky", err_timeout, 1);

        // Reset during RUN with two requests pending.
        request(4'b1000);
        tick;
        chk("reset_run_start", core_ap_start, 1);
        core_ap_ready = 1'b1;
        core_ap_idle = 1'b0;
        tick;
        core_ap_ready = 1'b0;
        req_start = 4'b0011;
        tick;
        req_start = '0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        core_ap_idle = 1'b1;
        chk("mid_rst_grant", req_grant, 0);
        chk("mid_rst_done", req_done, 0);
        chk("mid_rst_drop", req_drop, 0);
        chk("mid_rst_ap_start", core_ap_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_latency", last_latency, 0);
        chk("mid_rst_err", err_timeout, 0);
        pend_m = '0;
        ptr_m = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("lost_requests_start", core_ap_start, 0);
            chk("lost_requests_done", req_done, 0);
        end
        request(4'b1010);
        chk("ptr_reset_pick", pick(), 1);
        serve(1, 3, 1'b0, '0, waited);
        serve(0, 2, 1'b0, '0, waited);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fir_core_arbiter.md
# fir_core_arbiter

Round-robin scheduler that shares one `ap_ctrl_hs` FIR kernel (block-level `ap_start`/`ap_ready`/`ap_done`/`ap_idle`) between `NUM_REQ` requesters. Each requester issues single-cycle run requests. The arbiter grants one requester at a time, sequences the kernel handshake, and returns a per-requester done pulse. It also records the last run latency and flags runs that exceed a watchdog limit. The block sits between the requester logic and the FIR top, in the same clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `LAT_W`, 16 — width of the latency counter.
- `TIMEOUT`, 4096 — cycle count at which a run is flagged late; must be less than 2^LAT_W.

Ports:
- `clock` in 1 — single clock; all logic on the rising edge.
- `reset` in 1 — synchronous, active-high.
- `req_start` in NUM_REQ — 1-cycle request pulse per requester.
- `req_grant` out NUM_REQ — one-hot; held from START through DONE.
- `req_done` out NUM_REQ — 1-cycle pulse to the granted requester when its run completes.
- `req_drop` out NUM_REQ — 1-cycle pulse: a request pulse arrived while that requester's request was already pending.
- `core_ap_start` out 1 — kernel start.
- `core_ap_ready` in 1 — kernel accepted start.
- `core_ap_done` in 1 — kernel finished.
- `core_ap_idle` in 1 — kernel idle.
- `busy` out 1 — state is not IDLE.
- `grant_id` out $clog2(NUM_REQ) — index of the current or most recent grant.
- `last_latency` out LAT_W — cycles of the most recent completed run.
- `err_timeout` out 1 — sticky watchdog flag.

## Operation
- **Pending latch.** `pending[i]` is set on `req_start[i]`. It is cleared on the cycle requester i is granted.
  - Pulse while `pending[i]`=1: the pending bit stays set and `req_drop[i]` pulses the next cycle.
  - Pulse on the same cycle as the grant of i: becomes a new pending request; it is not dropped.
- **FSM states:** IDLE, START, RUN, DONE.
  - **IDLE:** when any `pending` bit is set and `core_ap_idle`=1, select the first set bit searching upward from `rr_ptr` with wrap-around. Then set `req_grant`, set `grant_id`, clear that pending bit, and go to START.
  - **START:** `core_ap_start`=1.
    - `core_ap_ready`=1 and `core_ap_done`=1 → DONE.
    - `core_ap_ready`=1 only → RUN.
    - Otherwise stay in START.
  - **RUN:** `core_ap_start`=0. `core_ap_done`=1 → DONE.
  - **DONE:** `req_done[grant_id]`=1 for exactly 1 cycle. `last_latency` ← latency counter. `rr_ptr` ← (`grant_id`+1) mod NUM_REQ. Go to IDLE. `req_grant` drops on the IDLE cycle.
- **Latency counter.**
  - Cleared on entry to START.
  - Increments every START/RUN cycle, including the `ap_done` cycle.
  - Saturates at 2^LAT_W−1.
- **Watchdog.**
  - When the counter equals TIMEOUT in START/RUN, `err_timeout` is set.
  - `err_timeout` is sticky until `reset`.
  - The FSM keeps waiting for `ap_done`; the kernel is never aborted.
- `core_ap_done` outside START/RUN is ignored.

## Timing
- Reset values:
  - State IDLE; `pending`=0; `rr_ptr`=0.
  - `req_grant`=0, `req_done`=0, `req_drop`=0.
  - `core_ap_start`=0, `busy`=0, `grant_id`=0.
  - `last_latency`=0, `err_timeout`=0.
- Reset mid-run: every output returns to its reset value on the next edge. Outstanding requests are lost. The kernel shares the same `reset`.
- Request to start: pulse at cycle N sets pending at N+1. With the FSM in IDLE and the kernel idle, `core_ap_start` is 1 from N+2.
- `core_ap_start` is registered, high only in START, and held until the `ap_ready` cycle. It is low the cycle after.
- Kernel `ap_done` at cycle D: `req_done` pulses at D+1 and `last_latency` updates at D+1. IDLE at D+2. The next grant can start its START state at D+3.
- `busy` = (state ≠ IDLE), registered.
- Back-to-back service: with all requesters pending, grants rotate 0,1,2,3,0,… No requester waits more than NUM_REQ−1 runs.

## Test plan
- **Single request.** `req_start[2]` pulse at cycle 10; kernel ready at 13, done at 20. Expect `core_ap_start` high during 12–13, `req_grant`=0100, `req_done[2]` at 21, `last_latency`=9, `rr_ptr`=3.
- **Round-robin.** Pulse all four requesters on the same cycle; kernel takes 5 cycles per run. Expect grant order 0,1,2,3, four `req_done` pulses, and no `req_drop`.
- **Ready with done.** `core_ap_ready` and `core_ap_done` both 1 in the first START cycle. Expect START→DONE directly, `last_latency`=1, and `core_ap_start` high for exactly 1 cycle.
- **Duplicate request.** `req_start[1]` pulsed twice while requester 0 is running. Expect `req_drop[1]` one cycle after the second pulse and exactly one run for requester 1.
- **Watchdog.** TIMEOUT=16; kernel done at 40 cycles. Expect `err_timeout` set once the counter reaches 16, `req_done` still delivered, `last_latency`=40, and the flag still 1 afterwards.
- **Reset mid-run.** Assert `reset` for 1 cycle during RUN with two requests pending. Expect all outputs at their reset values on the next cycle, no `req_done`, and a new request served from `rr_ptr`=0.
